// File: rtl/mem_arbiter_if.sv
// Per-master bus bundle for mem_arbiter: request/write/lock/address/data in, grant and read return out.
interface mem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 8
);
   logic          req;
   logic          we;
   logic          lock;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (
      output req, we, lock, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, lock, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single synchronous memory, with locked sequences and a lock idle timeout.
// Tie policy: fixed priority to port 0 unless ARB_ROUND_ROBIN_EN is defined (then alternate).
module mem_arbiter #(
   parameter int AW       = 16,
   parameter int DW       = 8,
   parameter int LOCK_MAX = 8
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  m0,
   mem_arbiter_if.slave  m1,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int IW = $clog2(LOCK_MAX + 1);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_P0   = 2'd1,
      OWN_P1   = 2'd2
   } owner_e;

   owner_e        lock_owner_q, lock_owner_d;
   logic [IW-1:0] idle_cnt_q, idle_cnt_d;
   logic          last_q, last_d;          // 0 = port 0, 1 = port 1
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_port_q, rsp_port_d;
   logic [AW-1:0] addr_q, addr_d;

   logic gnt0, gnt1, tie_to_p1;
   logic xfer, xfer_port, xfer_lock, xfer_we;
   logic rvalid0, rvalid1;
   logic [IW-1:0] idle_inc;

   // Grants depend only on requests and registered state, never on the lock inputs.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so no latch is inferred.
      gnt0 = 1'b0;
      gnt1 = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      tie_to_p1 = ~last_q;
`else
      tie_to_p1 = 1'b0;
`endif
      if (!rst) begin
         case (lock_owner_q)
            OWN_P0:  gnt0 = m0.req;
            OWN_P1:  gnt1 = m1.req;
            default: begin
               if (m0.req && m1.req) begin
                  gnt0 = ~tie_to_p1;
                  gnt1 = tie_to_p1;
               end else begin
                  gnt0 = m0.req;
                  gnt1 = m1.req;
               end
            end
         endcase
      end
   end

   assign xfer      = (m0.req & gnt0) | (m1.req & gnt1);
   assign xfer_port = m1.req & gnt1;
   assign xfer_lock = xfer_port ? m1.lock : m0.lock;
   assign xfer_we   = xfer_port ? m1.we   : m0.we;

   assign m0.gnt    = gnt0;
   assign m1.gnt    = gnt1;
   assign mem_addr  = rst  ? '0
                    : xfer ? (xfer_port ? m1.addr : m0.addr)
                    : addr_q;
   assign mem_we    = xfer & xfer_we;
   assign mem_wdata = xfer_port ? m1.wdata : m0.wdata;

   // Gating with rst hides a read that was in flight when reset arrived.
   assign rvalid0   = ~rst & rsp_valid_q & ~rsp_port_q;
   assign rvalid1   = ~rst & rsp_valid_q &  rsp_port_q;
   assign m0.rvalid = rvalid0;
   assign m1.rvalid = rvalid1;
   assign m0.rdata  = rvalid0 ? mem_rdata : '0;
   assign m1.rdata  = rvalid1 ? mem_rdata : '0;

   assign idle_inc  = idle_cnt_q + IW'(1);

   always_comb begin
      lock_owner_d = lock_owner_q;
      idle_cnt_d   = idle_cnt_q;
      last_d       = xfer ? xfer_port : last_q;
      rsp_valid_d  = xfer & ~xfer_we;
      rsp_port_d   = xfer_port;
      addr_d       = xfer ? mem_addr : addr_q;
      case (lock_owner_q)
         OWN_NONE: begin
            if (xfer && xfer_lock) begin
               lock_owner_d = xfer_port ? OWN_P1 : OWN_P0;
               idle_cnt_d   = '0;
            end
         end
         default: begin
            // Only the owner can transfer while a lock is held.
            if (xfer) begin
               idle_cnt_d = '0;
               if (!xfer_lock) lock_owner_d = OWN_NONE;
            end else if (idle_inc == IW'(LOCK_MAX)) begin
               lock_owner_d = OWN_NONE;
               idle_cnt_d   = '0;
            end else begin
               idle_cnt_d = idle_inc;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         lock_owner_q <= OWN_NONE;
         idle_cnt_q   <= '0;
         last_q       <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_port_q   <= 1'b0;
         addr_q       <= '0;
      end else begin
         lock_owner_q <= lock_owner_d;
         idle_cnt_q   <= idle_cnt_d;
         last_q       <= last_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_port_q   <= rsp_port_d;
         addr_q       <= addr_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected read returns, a negedge monitor pops and compares.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic [7:0]  mem [0:65535];

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         port;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   mem_arbiter_if #(.AW(16), .DW(8)) m0_if ();
   mem_arbiter_if #(.AW(16), .DW(8)) m1_if ();

   mem_arbiter #(.AW(16), .DW(8), .LOCK_MAX(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .m0        (m0_if.slave),
      .m1        (m1_if.slave),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Read-return monitor: order, cycle, port and data must all match the scoreboard head.
   always @(negedge clk) begin
      if (m0_if.rvalid !== 1'b0 || m1_if.rvalid !== 1'b0) begin
         if (sb.size() == 0) begin
            check("unexpected_rvalid", {30'd0, m1_if.rvalid, m0_if.rvalid}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("rsp_cycle", mon_e.cyc, cyc);
            check("rsp_port", {30'd0, m1_if.rvalid, m0_if.rvalid},
                  mon_e.port ? 32'd2 : 32'd1);
            check("rsp_data", mon_e.port ? m1_if.rdata : m0_if.rdata, mon_e.data);
            check("rsp_other_rdata", mon_e.port ? m0_if.rdata : m1_if.rdata, 32'd0);
         end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         check("missing_rvalid", 32'd0, 32'd1);
      end
   end

   task automatic drive(input bit p, input logic req, input logic we, input logic lock,
                        input logic [15:0] addr, input logic [7:0] wdata);
      if (p) begin
         m1_if.req = req; m1_if.we = we; m1_if.lock = lock; m1_if.addr = addr; m1_if.wdata = wdata;
      end else begin
         m0_if.req = req; m0_if.we = we; m0_if.lock = lock; m0_if.addr = addr; m0_if.wdata = wdata;
      end
   endtask

   task automatic idle(input bit p);
      drive(p, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_gnt(input string name, input bit g0, input bit g1);
      check({name, "_gnt0"}, {31'd0, m0_if.gnt}, {31'd0, g0});
      check({name, "_gnt1"}, {31'd0, m1_if.gnt}, {31'd0, g1});
   endtask

   task automatic expect_read(input bit p, input logic [7:0] data);
      sb.push_back('{port: p, data: data, cyc: cyc + 1});
   endtask

   logic [7:0] burst [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   bit w;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      mem[16'h0010] = 8'hA5;
      mem[16'h0300] = 8'h77;
      for (int i = 0; i < 4; i++) mem[16'h0100 + i] = burst[i];

      // Reset with both ports requesting.
      rst = 1'b1;
      drive(0, 1'b1, 1'b0, 1'b1, 16'h0010, 8'h00);
      drive(1, 1'b1, 1'b0, 1'b1, 16'h0300, 8'h00);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk_gnt("reset", 1'b0, 1'b0);
         check("reset_mem_we", {31'd0, mem_we}, 32'd0);
         check("reset_mem_addr", mem_addr, 32'd0);
         @(posedge clk);
      end
      #1;
      rst = 1'b0;
      idle(0); idle(1);
      #1;
      chk_gnt("post_reset", 1'b0, 1'b0);

      // Single read from port 0.
      tick(); drive(0, 1'b1, 1'b0, 1'b0, 16'h0010, 8'h00); #1;
      chk_gnt("single_read", 1'b1, 1'b0);
      check("single_read_addr", mem_addr, 32'h0010);
      expect_read(0, 8'hA5);
      tick(); idle(0); #1;
      check("hold_addr", mem_addr, 32'h0010);
      check("hold_we", {31'd0, mem_we}, 32'd0);

      // Port 1 write, then port 0 reads it back.
      tick(); drive(1, 1'b1, 1'b1, 1'b0, 16'h0200, 8'h3C); #1;
      chk_gnt("write", 1'b0, 1'b1);
      check("write_we", {31'd0, mem_we}, 32'd1);
      check("write_addr", mem_addr, 32'h0200);
      check("write_data", mem_wdata, 32'h3C);
      tick(); idle(1); drive(0, 1'b1, 1'b0, 1'b0, 16'h0200, 8'h00); #1;
      chk_gnt("read_back", 1'b1, 1'b0);
      expect_read(0, 8'h3C);
      tick(); idle(0); #1;
      check("hold_addr2", mem_addr, 32'h0200);

      // Port 1 alone, leaving it as the most recent transfer.
      tick(); drive(1, 1'b1, 1'b0, 1'b0, 16'h0300, 8'h00); #1;
      chk_gnt("m1_alone", 1'b0, 1'b1);
      expect_read(1, 8'h77);

      // Six cycles of simultaneous reads.
      for (int i = 0; i < 6; i++) begin
         tick();
         drive(0, 1'b1, 1'b0, 1'b0, 16'h0010, 8'h00);
         drive(1, 1'b1, 1'b0, 1'b0, 16'h0300, 8'h00);
         #1;
`ifdef ARB_ROUND_ROBIN_EN
         w = i[0];
`else
         w = 1'b0;
`endif
         chk_gnt("tie", ~w, w);
         expect_read(w, w ? 8'h77 : 8'hA5);
      end

      // Locked 4-byte burst from port 0 while port 1 keeps requesting.
      for (int i = 0; i < 4; i++) begin
         tick();
         drive(0, 1'b1, 1'b0, (i < 3), 16'h0100 + 16'(i), 8'h00);
         #1;
         chk_gnt("burst", 1'b1, 1'b0);
         expect_read(0, burst[i]);
      end
      tick(); idle(0); #1;
      chk_gnt("after_unlock", 1'b0, 1'b1);
      expect_read(1, 8'h77);

      // Lock timeout: port 1 locks with a write, then goes quiet.
      tick(); drive(1, 1'b1, 1'b1, 1'b1, 16'h0400, 8'h5A); #1;
      chk_gnt("lock_write", 1'b0, 1'b1);
      for (int k = 0; k < 8; k++) begin
         tick(); idle(1); drive(0, 1'b1, 1'b0, 1'b0, 16'h0010, 8'h00); #1;
         chk_gnt("locked_out", 1'b0, 1'b0);
      end
      tick(); #1;
      chk_gnt("lock_broken", 1'b1, 1'b0);
      expect_read(0, 8'hA5);

      // Reset discards a pending read and a fresh lock.
      tick(); drive(0, 1'b1, 1'b0, 1'b1, 16'h0010, 8'h00); #1;
      chk_gnt("pre_reset_lock", 1'b1, 1'b0);
      tick(); rst = 1'b1; idle(0); #1;
      chk_gnt("mid_reset", 1'b0, 1'b0);
      tick(); #1;
      tick(); rst = 1'b0; drive(1, 1'b1, 1'b0, 1'b0, 16'h0300, 8'h00); #1;
      chk_gnt("lock_cleared", 1'b0, 1'b1);
      expect_read(1, 8'h77);
      tick(); idle(1);
      tick();
      tick(); #1;
      check("scoreboard_empty", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 8-bit synchronous memory between the `cpu` instruction/data port (port 0) and a second bus master such as the program loader or debug port (port 1). Accepts at most one access per cycle, routes read data back to the issuing port one cycle later, and supports locked sequences so a master can complete a multi-byte access, such as a 4-byte instruction fetch, without interleaving.

## Interface

Parameters:
- `AW`, 16, address width.
- `DW`, 8, data width.
- `LOCK_MAX`, 8, idle cycles a lock survives without a transfer from its owner before it is broken.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0_req`  in  1  port 0 requests an access this cycle.
- `m0_we`  in  1  port 0 access is a write.
- `m0_lock`  in  1  keep ownership after this transfer.
- `m0_addr`  in  AW  port 0 address.
- `m0_wdata`  in  DW  port 0 write data.
- `m0_gnt`  out  1  port 0 access accepted this cycle (combinational).
- `m0_rvalid`  out  1  port 0 read data valid.
- `m0_rdata`  out  DW  port 0 read data.
- `m1_*`: same set as `m0_*`, for port 1.
- `mem_addr`  out  AW  memory address.
- `mem_we`  out  1  memory write strobe.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid one cycle after address.

## Operation

Transfers:
- A transfer occurs when `mX_req && mX_gnt`.
- At most one grant is high per cycle.
- `mem_addr`, `mem_we` and `mem_wdata` are muxed combinationally from the granted port.
- With no grant, `mem_we`=0 and `mem_addr` holds the last granted address.

Lock state (`lock_owner`: NONE/P0/P1, `idle_cnt`):
- **NONE:** arbitrate among requesting ports.
- **PX:** only port X may be granted. The other port's grant is 0 even if port X is not requesting.
- A transfer from the owner with `lock`=1 keeps ownership and clears `idle_cnt`.
- A transfer from the owner with `lock`=0 returns the state to NONE.
- In NONE, a granted transfer with `lock`=1 sets the owner to that port.
- Each cycle the owner makes no transfer, `idle_cnt` increments. When it reaches `LOCK_MAX`, the owner becomes NONE and `idle_cnt` clears.

Read return:
- `rsp_port` and `rsp_valid` registers capture the port of each read transfer.
- The next cycle, `mX_rvalid`=1 for that port only, and `mX_rdata` = `mem_rdata`.
- `mX_rdata` is 0 when `mX_rvalid`=0.

Arbitration in NONE (see Configuration):
- If only one port requests, it wins.
- Simultaneous requests are resolved by the arbitration policy.
- `last` records the port of the most recent transfer.

Reset:
- `lock_owner`=NONE, `idle_cnt`=0, `last`=P1, `rsp_valid`=0.
- While `rst`=1: both grants 0, both rvalid 0, `mem_we`=0, `mem_addr`=0, both rdata 0.
- A lock or pending read in flight at reset is discarded. No rvalid is issued for it after reset deasserts.

## Timing

- Grant: same cycle as request, combinational from `mX_req` and registered state. There is no combinational path from `mX_lock` to `mX_gnt`.
- Write: committed at the rising edge ending the grant cycle.
- Read latency: `mX_rvalid` exactly 1 cycle after the transfer cycle. Back-to-back reads give rvalid on consecutive cycles, possibly alternating ports.
- Lock takes effect on the cycle after the locking transfer.
- Lock break: the owner regains NONE status on the edge where `idle_cnt` reaches `LOCK_MAX`. The other port can be granted the following cycle.
- A request held without grant must remain stable. The arbiter does not queue requests.

## Configuration

- `ARB_ROUND_ROBIN_EN`:
  - **Defined:** on simultaneous requests in NONE, grant the port ≠ `last`. Requesters alternate.
  - **Undefined:** fixed priority, port 0 always wins a tie. `last` is still maintained but unused.

## Test plan

- **Reset:** assert `rst` for 3 cycles with both requests high → both grants 0, `mem_we`=0, no rvalid during reset or on the cycle after release.
- **Single read:** preload mem[0x0010]=0xA5. m0 reads 0x0010 → `m0_gnt`=1 in cycle t, `m0_rvalid`=1 with `m0_rdata`=0xA5 at t+1, `m1_rvalid`=0.
- **Locked burst:** m0 does 4 reads at 0x0100..0x0103 with lock=1,1,1,0 while m1 requests continuously → m0 gets 4 consecutive grants (first cycle is a tie). m1 is granted in the cycle after m0's unlock transfer.
- **Tie policy:** both ports request reads every cycle for 6 cycles, no lock.
  - With the macro: grants alternate m0, m1, m0, … (m0 first after reset).
  - Without the macro: m0 wins all 6.
- **Lock timeout:** with `LOCK_MAX`=8, m1 transfers with lock=1 then drops `m1_req`, while m0 requests → `m0_gnt` stays 0 for 8 cycles, then m0 is granted on the 9th cycle.
- **Write then read:** m1 writes 0x3C to 0x0200, next cycle m0 reads 0x0200 → `m0_rdata`=0x3C with `m0_rvalid`; no rvalid is issued for the write.
